// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-cache slice.
// Provides the refill FSM state type, the NOP word driven on a miss, and
// helpers that derive the pc field widths from the cache geometry.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REFILL    = 2'd1,
        FILL_DONE = 2'd2
    } cacheState_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    // Word-offset field width: log2(words per line).
    function automatic int unsigned offsetBits(input int unsigned wordsPerLine);
        return $clog2(wordsPerLine);
    endfunction

    // Line-index field width: log2(number of lines).
    function automatic int unsigned indexBits(input int unsigned lines);
        return $clog2(lines);
    endfunction

    // Tag width: whatever remains of the word address above index and offset.
    function automatic int unsigned tagBits(input int unsigned lines, input int unsigned wordsPerLine);
        return 32 - 2 - offsetBits(wordsPerLine) - indexBits(lines);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage of the direct-mapped instruction cache.
// Ports:
//   clk, rst                 clock, synchronous active-high reset (clears valid only)
//   rdIndex, rdOffset        combinational read address
//   rdValid, rdTag, rdWord   combinational read data for the addressed line/word
//   wrEn, wrIndex, wrOffset, wrData   single-word data write
//   tagWrEn, wrTag           tag write + valid set for line wrIndex
module icache_array
    import mips_pkg::*;
#(
    parameter int unsigned LINES          = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [indexBits(LINES)-1:0]                rdIndex,
    input  logic [offsetBits(WORDS_PER_LINE)-1:0]      rdOffset,
    output logic                                       rdValid,
    output logic [tagBits(LINES, WORDS_PER_LINE)-1:0]  rdTag,
    output logic [31:0]                                rdWord,
    input  logic                                       wrEn,
    input  logic [indexBits(LINES)-1:0]                wrIndex,
    input  logic [offsetBits(WORDS_PER_LINE)-1:0]      wrOffset,
    input  logic [31:0]                                wrData,
    input  logic                                       tagWrEn,
    input  logic [tagBits(LINES, WORDS_PER_LINE)-1:0]  wrTag
);

    localparam int unsigned TB = tagBits(LINES, WORDS_PER_LINE);

    logic [LINES-1:0] validBits;
    logic [TB-1:0]    tagMem  [LINES];
    logic [31:0]      dataMem [LINES][WORDS_PER_LINE];

    // Valid bits are the only state cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            validBits <= '0;
        end else if (tagWrEn) begin
            validBits[wrIndex] <= 1'b1;
        end
    end

    // Tag and data arrays keep their contents across reset.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            dataMem[wrIndex][wrOffset] <= wrData;
        end
        if (tagWrEn) begin
            tagMem[wrIndex] <= wrTag;
        end
    end

    assign rdValid = validBits[rdIndex];
    assign rdTag   = tagMem[rdIndex];
    assign rdWord  = dataMem[rdIndex][rdOffset];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller.
// Answers the fetch lookup combinationally in IDLE and, on a miss, refills the
// whole line from backing memory one word per mem_req/mem_ready handshake.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   pc                    fetch address (bits [1:0] ignored)
//   instruction, hit      lookup result; hit=0 stalls the pipeline
//   mem_req, mem_addr     registered refill word request and address
//   mem_ready, mem_rdata  backing-memory accept strobe and data
module icache_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned LINES          = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        hit,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned OB = offsetBits(WORDS_PER_LINE);
    localparam int unsigned IB = indexBits(LINES);
    localparam int unsigned TB = tagBits(LINES, WORDS_PER_LINE);
    localparam int unsigned LW = TB + IB;

    cacheState_t   state, nextState;
    logic [LW-1:0] refillLine, nextLine;
    logic [OB-1:0] wordCnt, nextCnt;

    logic          rdValid;
    logic [TB-1:0] rdTag;
    logic [31:0]   rdWord;
    logic          lookupHit;
    logic          lastWord;
    logic          fillWrEn;
    logic          tagWrEn;
    logic          unusedPcBits;

    assign unusedPcBits = ^pc[1:0];

    icache_array #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rdIndex  (pc[OB+IB+1:OB+2]),
        .rdOffset (pc[OB+1:2]),
        .rdValid  (rdValid),
        .rdTag    (rdTag),
        .rdWord   (rdWord),
        .wrEn     (fillWrEn),
        .wrIndex  (refillLine[IB-1:0]),
        .wrOffset (wordCnt),
        .wrData   (mem_rdata),
        .tagWrEn  (tagWrEn),
        .wrTag    (refillLine[LW-1:IB])
    );

    assign lookupHit = rdValid && (rdTag == pc[31:OB+IB+2]);
    assign lastWord  = (wordCnt == OB'(WORDS_PER_LINE - 1));

    // State, refill line/counter and the registered memory request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            refillLine <= '0;
            wordCnt    <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
        end else begin
            state      <= nextState;
            refillLine <= nextLine;
            wordCnt    <= nextCnt;
            mem_req    <= (nextState == REFILL);
            mem_addr   <= (nextState == REFILL) ? {nextLine, nextCnt, 2'b00} : '0;
        end
    end

    // Lookup, miss capture and refill sequencing. Reset wins over a
    // concurrent transfer, so array writes are suppressed while rst is high.
    always_comb begin
        nextState   = state;
        nextLine    = refillLine;
        nextCnt     = wordCnt;
        fillWrEn    = 1'b0;
        tagWrEn     = 1'b0;
        hit         = 1'b0;
        instruction = NOP;
        case (state)
            IDLE: begin
                if (lookupHit) begin
                    hit         = 1'b1;
                    instruction = rdWord;
                end else begin
                    nextState = REFILL;
                    nextLine  = pc[31:OB+2];
                    nextCnt   = '0;
                end
            end
            REFILL: begin
                if (mem_ready) begin
                    fillWrEn = !rst;
                    tagWrEn  = !rst && lastWord;
                    nextCnt  = wordCnt + OB'(1);
                    if (lastWord) begin
                        nextState = FILL_DONE;
                    end
                end
            end
            FILL_DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_icache_ctrl.sv
module tb_icache_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        hit;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    icache_ctrl #(.LINES(16), .WORDS_PER_LINE(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .instruction (instruction),
        .hit         (hit),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing memory: word at address A holds A + 0x1000.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[31:2], 2'b00} + 32'h0000_1000;
    endfunction

    // Memory responder: waits curWait cycles per word, logs accepted addresses,
    // and checks the request stays stable while stalled.
    int          waitCfg   = 0;
    bit          randWaits = 0;
    int          waitCnt   = 0;
    int          curWait   = 0;
    logic [31:0] xferQ[$];
    logic        lastReq   = 1'b0;
    logic        lastReady = 1'b0;
    logic        lastRst   = 1'b1;
    logic [31:0] lastAddr  = 32'h0;

    always @(negedge clk) begin
        #1;
        if (lastReq && !lastReady && !lastRst) begin
            chk(mem_req == 1'b1, "reqHeld", 32'(mem_req), 32'h1);
            chk(mem_addr == lastAddr, "addrHeld", mem_addr, lastAddr);
        end
        if (mem_req) begin
            if (waitCnt >= curWait) begin
                mem_ready = 1'b1;
                mem_rdata = memWord(mem_addr);
                waitCnt   = 0;
                curWait   = randWaits ? int'($urandom_range(0, 2)) : waitCfg;
                if (!rst) xferQ.push_back(mem_addr);
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                waitCnt++;
            end
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            waitCnt   = 0;
            curWait   = randWaits ? int'($urandom_range(0, 2)) : waitCfg;
        end
        lastReq   = mem_req;
        lastReady = mem_ready;
        lastRst   = rst;
        lastAddr  = mem_addr;
    end

    // Leaves rst asserted; the next access deasserts it.
    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk(hit == 1'b0, "rstHit", 32'(hit), 32'h0);
        chk(instruction == 32'h0, "rstInstr", instruction, 32'h0);
        chk(mem_req == 1'b0, "rstReq", 32'(mem_req), 32'h0);
        chk(mem_addr == 32'h0, "rstAddr", mem_addr, 32'h0);
    endtask

    task automatic waitHit(output int lat);
        bit ok = 0;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            lat++;
            if (hit) begin
                ok = 1;
                break;
            end
            chk(instruction == 32'h0, "stallInstr", instruction, 32'h0);
        end
        if (!ok) chk(1'b0, "hitTimeout", 32'(lat), 32'd200);
    endtask

    task automatic checkLine(input logic [31:0] pcV, input int first, input string name);
        logic [31:0] base = {pcV[31:4], 4'h0};
        chk(xferQ.size() >= first + 4, {name, "XferCnt"}, 32'(xferQ.size()), 32'(first + 4));
        for (int w = 0; w < 4; w++) begin
            if (xferQ.size() > first + w)
                chk(xferQ[first + w] == base + 32'(4 * w), {name, "XferAddr"}, xferQ[first + w], base + 32'(4 * w));
        end
    endtask

    // One fetch: apply pc, check immediate hit/miss, then on a miss check refill,
    // latency (if expLat >= 0) and the delivered instruction.
    task automatic runAccess(input logic [31:0] pcV, input bit expHit, input logic [31:0] expInstr,
                             input int expLat, input string name);
        int lat;
        @(negedge clk);
        rst = 1'b0;
        pc  = pcV;
        xferQ.delete();
        #2;
        chk(hit == expHit, {name, "Hit"}, 32'(hit), 32'(expHit));
        chk(mem_req == 1'b0, {name, "IdleReq"}, 32'(mem_req), 32'h0);
        if (hit) begin
            chk(instruction == expInstr, {name, "Instr"}, instruction, expInstr);
        end else begin
            waitHit(lat);
            if (expLat >= 0) chk(lat == expLat, {name, "Lat"}, 32'(lat), 32'(expLat));
            chk(instruction == expInstr, {name, "FillInstr"}, instruction, expInstr);
            checkLine(pcV, 0, name);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        bit          expHit;
        logic [31:0] expInstr;
        int          expLat;
    } vec_t;

    vec_t vecs[10];
    bit   mValid [16];
    logic [23:0] mTag [16];

    initial begin
        int lat;
        logic [31:0] pcV;
        rst       = 1'b1;
        pc        = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;

        vecs[0] = '{32'h0000_0000, 1'b0, 32'h0000_1000, 6};
        vecs[1] = '{32'h0000_0008, 1'b1, 32'h0000_1008, 0};
        vecs[2] = '{32'h0000_0004, 1'b1, 32'h0000_1004, 0};
        vecs[3] = '{32'h0000_0100, 1'b0, 32'h0000_1100, 6};
        vecs[4] = '{32'h0000_0000, 1'b0, 32'h0000_1000, 6};
        vecs[5] = '{32'h0000_003C, 1'b0, 32'h0000_103C, 6};
        vecs[6] = '{32'h0000_0030, 1'b1, 32'h0000_1030, 0};
        vecs[7] = '{32'h0000_004C, 1'b0, 32'h0000_104C, 6};
        vecs[8] = '{32'h0000_0002, 1'b1, 32'h0000_1000, 0};
        vecs[9] = '{32'h0000_010C, 1'b0, 32'h0000_110C, 6};

        // Table: cold miss, same-line hits, conflict eviction, ignored pc[1:0].
        doReset();
        for (int i = 0; i < 10; i++) begin
            runAccess(vecs[i].pc, vecs[i].expHit, vecs[i].expInstr, vecs[i].expLat, $sformatf("vec%0d", i));
        end

        // Two wait cycles per word.
        waitCfg = 2;
        doReset();
        runAccess(32'h0, 1'b0, 32'h0000_1000, 14, "wait");
        runAccess(32'h4, 1'b1, 32'h0000_1004, 0, "waitHit");
        waitCfg = 0;

        // Reset after the second transfer of a refill.
        doReset();
        @(negedge clk);
        rst = 1'b0;
        pc  = 32'h0;
        xferQ.delete();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #2;
            if (xferQ.size() >= 2) break;
        end
        chk(xferQ.size() == 2, "midXfers", 32'(xferQ.size()), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        xferQ.delete();
        #2;
        chk(mem_req == 1'b0, "midRstReq", 32'(mem_req), 32'h0);
        chk(mem_addr == 32'h0, "midRstAddr", mem_addr, 32'h0);
        chk(hit == 1'b0, "midNoStale", 32'(hit), 32'h0);
        waitHit(lat);
        chk(lat == 6, "midLat", 32'(lat), 32'd6);
        chk(instruction == 32'h0000_1000, "midInstr", instruction, 32'h0000_1000);
        checkLine(32'h0, 0, "mid");

        // pc moves during a refill: the captured line still completes first.
        doReset();
        @(negedge clk);
        rst = 1'b0;
        pc  = 32'h0;
        xferQ.delete();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #2;
            if (xferQ.size() >= 2) break;
        end
        @(negedge clk);
        pc = 32'h40;
        waitHit(lat);
        chk(instruction == 32'h0000_1040, "pcChgInstr", instruction, 32'h0000_1040);
        chk(xferQ.size() == 8, "pcChgXfers", 32'(xferQ.size()), 32'd8);
        checkLine(32'h0, 0, "pcChgA");
        checkLine(32'h40, 4, "pcChgB");
        runAccess(32'h0, 1'b1, 32'h0000_1000, 0, "pcChgOld");

        // Random accesses with random waits against a line-level model.
        randWaits = 1;
        doReset();
        for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
        for (int i = 0; i < 60; i++) begin
            int idx;
            bit expHit;
            pcV = {$urandom_range(0, 1) == 1 ? 8'h80 : 8'h00, 14'h0, 2'($urandom_range(0, 3)),
                   4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            idx    = int'(pcV[7:4]);
            expHit = mValid[idx] && (mTag[idx] == pcV[31:8]);
            runAccess(pcV, expHit, memWord(pcV), -1, "rand");
            mValid[idx] = 1'b1;
            mTag[idx]   = pcV[31:8];
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped instruction cache controller that answers the fetch stage's per-cycle instruction lookup. It returns `instruction` and `hit` for the current `pc`. On a miss it holds `hit` low, which stalls the IF/ID, ID/EX, EX/MEM and MEM/WB registers. While stalled it refills the missing line from backing instruction memory over a request/ready handshake. It sits between the fetch stage and the instruction memory.

## Interface
Parameters:
- `LINES`, 16: number of cache lines; power of 2, at least 2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of 2, at least 2.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc`  in  32  fetch address; bits [1:0] ignored.
- `instruction`  out  32  cached word for `pc`; valid only when `hit`=1.
- `hit`  out  1  `pc` hits in the cache and the controller is idle.
- `mem_req`  out  1  refill word request.
- `mem_addr`  out  32  word-aligned refill address.
- `mem_ready`  in  1  backing memory accepts the request and presents `mem_rdata` this cycle.
- `mem_rdata`  in  32  refill data.

## Operation
- Address split, with OB = log2(WORDS_PER_LINE) and IB = log2(LINES):
  - word offset = `pc[OB+1:2]`
  - index = `pc[OB+IB+1:OB+2]`
  - tag = `pc[31:OB+IB+2]`
- Storage is a per-line valid bit, a tag array and a data array of LINES×WORDS_PER_LINE words. All are flops with a combinational read.
- FSM states:
  - IDLE: lookup. `hit` = valid[index] && tag match. `instruction` = data[index][offset] when hit, else 0. On a miss, capture `pc[31:OB+2]` as the refill line, set word counter = 0, and go to REFILL.
  - REFILL: `mem_req`=1, `mem_addr` = {line, counter, 2'b00}.
    - On `mem_req && mem_ready`: write `mem_rdata` into data[line index][counter] and increment the counter.
    - On the last word: write tag, set valid, go to FILL_DONE.
  - FILL_DONE: one bubble cycle with `hit`=0, then IDLE.
- `hit`=0 and `instruction`=0 in REFILL and FILL_DONE, regardless of `pc`.
- Changes on `pc` during REFILL are ignored. The captured line always completes, and the new `pc` is looked up after return to IDLE.
- Replacement: a refill overwrites the indexed line unconditionally. No write path exists; this is an instruction cache only.
- Reset, in any state including mid-refill:
  - all valid bits cleared, FSM to IDLE, counter cleared.
  - `mem_req`=0, `mem_addr`=0, `hit`=0, `instruction`=0 from the cycle after `rst` is sampled.
  - data and tag arrays are not cleared.

## Timing
- Hit latency: 0 cycles. `hit` and `instruction` are combinational from `pc` in IDLE.
- Miss penalty:
  - 1 cycle, the IDLE miss detect
  - plus the sum over words of (wait cycles + 1)
  - plus 1 FILL_DONE cycle
  - then the hit appears in IDLE.
  - With zero-wait memory and WORDS_PER_LINE=4, `hit` rises 6 cycles after the miss cycle.
- Handshake:
  - `mem_req` and `mem_addr` change only on a clock edge, and stay stable while `mem_req`=1 and `mem_ready`=0.
  - A transfer occurs only on a cycle where both `mem_req` and `mem_ready` are 1; `mem_ready` is ignored when `mem_req`=0.
  - `mem_req` drops in the cycle after the last transfer.
- `rst` takes priority over any concurrent `mem_ready` transfer; that word is discarded.

## Structure
- Shared package `mips_pkg`:
  - FSM state enum (IDLE, REFILL, FILL_DONE)
  - NOP constant 32'h0000_0000
  - address-field width helper functions (offset/index/tag widths from LINES, WORDS_PER_LINE)
- One sub-module: `icache_array`. It holds the valid, tag and data storage, with a combinational read port and a synchronous single-word write port plus a tag/valid write. `icache_ctrl` holds the FSM, counter and handshake.

## Test plan
- Cold miss: reset, `pc`=0x0000_0000, zero-wait memory returning address+0x1000.
  - Required: `mem_addr` sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles.
  - Then `hit`=1 with `instruction`=0x0000_1000.
- Same-line hit: after the cold miss, `pc`=0x8 → `hit`=1 in the same cycle, `instruction`=0x0000_1008, `mem_req` stays 0.
- Conflict eviction: `pc`=0x100, which maps to index 0 → refill from 0x100..0x10C, then `hit`=1 with `instruction`=0x0000_1100. Then `pc`=0x0 → miss and refill again.
- Wait states: `mem_ready` low for 2 cycles per word → `mem_addr` held stable during the waits; `hit` rises 14 cycles after the miss cycle.
- Reset mid-refill: assert `rst` after the 2nd transfer.
  - Required: `mem_req`=0 the next cycle.
  - After reset release with `pc`=0x0: a full 4-word refill starting at 0x0; no stale hit.
- `pc` change during refill: switch `pc` from 0x0 to 0x40 mid-refill → line 0x0 still completes. Then 0x40 misses and refills 0x40..0x4C.
